// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator: FSM states and
// the default pattern geometry.
package seq_pkg;

  localparam int DEF_PAT_W = 4;
  localparam int DEF_CNT_W = 4;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b0101;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } state_t;

endpackage

// File: rtl/seq_cnt.sv
// Loadable down-counter that saturates at zero and reports when it
// has reached zero.
module seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator: sends a fixed or runtime pattern MSB first,
// repeated a given number of times with optional idle gaps in between.
module seq_gen
  import seq_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pat_sel,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [CNT_W-1:0] reps,
  input  logic [CNT_W-1:0] gap,
  output logic             dout,
  output logic             dvalid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = $clog2(PAT_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PAT_W - 1);

  state_t state, state_d;
  logic [PAT_W-1:0] pat_reg, pat_src, shreg, shreg_d;
  logic [CNT_W-1:0] gap_reg;
  logic pat_load;
  logic dout_d, dvalid_d, busy_d, done_d;
  logic bit_load, bit_dec, bit_zero;
  logic rep_load, rep_dec, rep_zero;
  logic gap_load, gap_dec, gap_zero;

  assign pat_src = pat_sel ? pat_in : PATTERN;

  // The bit counter holds bits still to come after the one on dout.
  seq_cnt #(.W(BIT_W)) u_bit_cnt (
    .clk(clk), .reset(reset), .load(bit_load), .dec(bit_dec),
    .load_val(LAST_BIT), .zero(bit_zero)
  );

  // The rep counter holds repetitions still to come after the current one.
  seq_cnt #(.W(CNT_W)) u_rep_cnt (
    .clk(clk), .reset(reset), .load(rep_load), .dec(rep_dec),
    .load_val(reps - CNT_W'(1)), .zero(rep_zero)
  );

  seq_cnt #(.W(CNT_W)) u_gap_cnt (
    .clk(clk), .reset(reset), .load(gap_load), .dec(gap_dec),
    .load_val(gap_reg - CNT_W'(1)), .zero(gap_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      dout    <= 1'b0;
      dvalid  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      pat_reg <= '0;
      gap_reg <= '0;
    end else begin
      state  <= state_d;
      dout   <= dout_d;
      dvalid <= dvalid_d;
      busy   <= busy_d;
      done   <= done_d;
      shreg  <= shreg_d;
      if (pat_load) begin
        pat_reg <= pat_src;
        gap_reg <= gap;
      end
    end
  end

  // Outputs are computed one cycle ahead so they leave the flops cleanly;
  // the shift register's MSB always mirrors the bit currently on dout.
  always_comb begin
    state_d  = state;
    dout_d   = 1'b0;
    dvalid_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    shreg_d  = shreg;
    pat_load = 1'b0;
    bit_load = 1'b0;
    bit_dec  = 1'b0;
    rep_load = 1'b0;
    rep_dec  = 1'b0;
    gap_load = 1'b0;
    gap_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pat_load = 1'b1;
          if (reps == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = SEND;
            shreg_d  = pat_src;
            dout_d   = pat_src[PAT_W-1];
            dvalid_d = 1'b1;
            busy_d   = 1'b1;
            bit_load = 1'b1;
            rep_load = 1'b1;
          end
        end
      end
      SEND: begin
        if (!bit_zero) begin
          bit_dec  = 1'b1;
          shreg_d  = {shreg[PAT_W-2:0], 1'b0};
          dout_d   = shreg[PAT_W-2];
          dvalid_d = 1'b1;
          busy_d   = 1'b1;
        end else if (rep_zero) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          rep_dec = 1'b1;
          busy_d  = 1'b1;
          if (gap_reg == '0) begin
            bit_load = 1'b1;
            shreg_d  = pat_reg;
            dout_d   = pat_reg[PAT_W-1];
            dvalid_d = 1'b1;
          end else begin
            state_d  = GAP;
            gap_load = 1'b1;
          end
        end
      end
      GAP: begin
        busy_d = 1'b1;
        if (gap_zero) begin
          state_d  = SEND;
          bit_load = 1'b1;
          shreg_d  = pat_reg;
          dout_d   = pat_reg[PAT_W-1];
          dvalid_d = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_gen.sv
// Self-checking bench for seq_gen: per-cycle traces are compared against
// a reference stream built directly from pattern, reps and gap.
module tb_seq_gen;

  localparam logic [3:0] DEF_PAT = 4'b0101;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic pat_sel;
  logic [3:0] pat_in;
  logic [3:0] reps;
  logic [3:0] gap;
  logic dout, dvalid, busy, done;

  int total = 0;
  int bad = 0;

  logic [3:0] obs_q[$];
  logic [3:0] exp_q[$];
  logic       z_q[$];

  // Loopback 0101 detector fed from dout; z fires on the completing bit.
  logic [2:0] hist;
  logic z;

  seq_gen dut (
    .clk(clk), .reset(reset), .start(start), .pat_sel(pat_sel),
    .pat_in(pat_in), .reps(reps), .gap(gap),
    .dout(dout), .dvalid(dvalid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset) begin
    if (!reset) hist <= 3'b000;
    else        hist <= {hist[1:0], dout};
  end

  assign z = ({hist, dout} == 4'b0101);

  // Expected {dout,dvalid,busy,done} per cycle after the accepting edge.
  task automatic build_exp(input logic sel, input logic [3:0] pin, input int r, input int g);
    logic [3:0] pat;
    exp_q.delete();
    pat = sel ? pin : DEF_PAT;
    for (int k = 0; k < r; k++) begin
      for (int b = 3; b >= 0; b--) exp_q.push_back({pat[b], 3'b110});
      if (k < r - 1)
        for (int j = 0; j < g; j++) exp_q.push_back(4'b0010);
    end
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0000);
    exp_q.push_back(4'b0000);
  endtask

  // Issues one start and records the outputs; inputs are scrambled after
  // acceptance, and with noise set start is also toggled while busy.
  task automatic run_txn(input logic sel, input logic [3:0] pin, input int r, input int g,
                         input bit noise);
    build_exp(sel, pin, r, g);
    obs_q.delete();
    z_q.delete();
    @(negedge clk);
    start   = 1'b1;
    pat_sel = sel;
    pat_in  = pin;
    reps    = 4'(r);
    gap     = 4'(g);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs_q.push_back({dout, dvalid, busy, done});
      z_q.push_back(z);
      start   = (noise && (i < exp_q.size() - 3)) ? 1'($urandom_range(0, 1)) : 1'b0;
      pat_sel = 1'($urandom_range(0, 1));
      pat_in  = 4'($urandom_range(0, 15));
      reps    = 4'($urandom_range(0, 15));
      gap     = 4'($urandom_range(0, 15));
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    total++;
    if ({dout, dvalid, busy, done} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_hold got=%b want=0000", {dout, dvalid, busy, done});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total++;
    if ({dout, dvalid, busy, done} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_idle got=%b want=0000", {dout, dvalid, busy, done});
    end
  endtask

  task automatic test_default_pattern;
    run_txn(1'b0, 4'b1111, 1, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL default_pat cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_runtime_gap;
    int nbusy;
    run_txn(1'b1, 4'b1100, 2, 3, 1'b0);
    nbusy = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_q[i][1]) nbusy++;
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL runtime_gap cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (nbusy != 11) begin
      bad++;
      $display("[TB] FAIL busy_len got=%0d want=11", nbusy);
    end
  endtask

  task automatic test_zero_reps;
    run_txn(1'b1, 4'b1010, 0, 2, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL zero_reps cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_start_while_busy;
    int ndone;
    run_txn(1'b1, 4'b1011, 2, 1, 1'b1);
    ndone = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (obs_q[i][0]) ndone++;
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL busy_start cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
    total++;
    if (ndone != 1) begin
      bad++;
      $display("[TB] FAIL done_count got=%0d want=1", ndone);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    start   = 1'b1;
    pat_sel = 1'b0;
    reps    = 4'd2;
    gap     = 4'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    total++;
    if (dvalid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mid_bit2 dvalid got=%b want=1", dvalid);
    end
    #1 reset = 1'b0;
    #1;
    total++;
    if ({dout, dvalid, busy, done} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL mid_reset got=%b want=0000", {dout, dvalid, busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({dout, dvalid, busy, done} !== 4'b0000) begin
        bad++;
        $display("[TB] FAIL reset_held cyc%0d got=%b want=0000", i, {dout, dvalid, busy, done});
      end
    end
    reset = 1'b1;
    run_txn(1'b0, 4'b0000, 1, 0, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("[TB] FAIL after_reset cyc%0d got=%b want=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random;
    logic sel;
    logic [3:0] pin;
    int r, g;
    for (int t = 0; t < 20; t++) begin
      sel = 1'($urandom_range(0, 1));
      pin = 4'($urandom_range(0, 15));
      r   = int'($urandom_range(0, 4));
      g   = int'($urandom_range(0, 3));
      run_txn(sel, pin, r, g, 1'($urandom_range(0, 1)));
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("[TB] FAIL random t%0d cyc%0d sel=%b pin=%b r=%0d g=%0d got=%b want=%b",
                   t, i, sel, pin, r, g, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_loopback;
    int nz;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (z !== 1'b0) begin
        bad++;
        $display("[TB] FAIL loop_idle_pre cyc%0d z got=%b want=0", i, z);
      end
    end
    run_txn(1'b0, 4'b0000, 3, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      nz = 0;
      for (int i = 4 * k; i < 4 * k + 4; i++) if (z_q[i]) nz++;
      total++;
      if (nz < 1) begin
        bad++;
        $display("[TB] FAIL loop_rep%0d z_count got=%0d want>=1", k, nz);
      end
    end
    for (int i = 12; i < z_q.size(); i++) begin
      total++;
      if (z_q[i] !== 1'b0) begin
        bad++;
        $display("[TB] FAIL loop_idle_post cyc%0d z got=%b want=0", i, z_q[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout reached");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    pat_sel = 1'b0;
    pat_in  = 4'b0000;
    reps    = 4'd0;
    gap     = 4'd0;
    test_reset;
    test_default_pattern;
    test_runtime_gap;
    test_zero_reps;
    test_start_while_busy;
    test_reset_mid;
    test_random;
    test_loopback;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 SHALL have parameter PAT_W, default 4, pattern length in bits (2..16).
REQ-002 SHALL have parameter PATTERN, default 4'b0101, pattern sent when pat_sel=0.
REQ-003 SHALL have parameter CNT_W, default 4, width of the reps and gap fields.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  request to begin a transmission; sampled only in IDLE.
REQ-007 SHALL have port pat_sel  input  1  0: send PATTERN; 1: send pat_in.
REQ-008 SHALL have port pat_in  input  PAT_W  runtime pattern, sampled on the accepted start.
REQ-009 SHALL have port reps  input  CNT_W  repetition count, sampled on the accepted start.
REQ-010 SHALL have port gap  input  CNT_W  idle cycles between repetitions, sampled on the accepted start.
REQ-011 SHALL have port dout  output  1  serial bit stream, MSB first.
REQ-012 SHALL have port dvalid  output  1  high on cycles where dout carries a pattern bit.
REQ-013 SHALL have port busy  output  1  high in states SEND and GAP.
REQ-014 SHALL have port done  output  1  one-cycle pulse at the end of a transmission.

Function
REQ-015 SHALL implement the FSM states IDLE, SEND, GAP and DONE, with all outputs registered.
REQ-016 SHALL accept start only in IDLE; on acceptance it latches the pattern (per pat_sel), reps and gap, and enters SEND, or enters DONE directly when reps=0.
REQ-017 SHALL present the pattern MSB on dout with dvalid=1 in the cycle after the accepted start, then one bit per cycle for PAT_W cycles.
REQ-018 SHALL, after the last bit of a repetition with reps remaining and gap>0, enter GAP for exactly gap cycles with dout=0 and dvalid=0, then return to SEND.
REQ-019 SHALL, after the last bit of a repetition with reps remaining and gap=0, start the next repetition on the following cycle with no break in dvalid.
REQ-020 SHALL, after the final bit of the final repetition, enter DONE for one cycle (done=1, busy=0, dvalid=0, dout=0) and then go to IDLE.
REQ-021 SHALL ignore start, and all changes to pat_in, reps, gap and pat_sel, while in SEND, GAP or DONE.
REQ-022 SHALL hold dout=0, dvalid=0, busy=0 and done=0 in IDLE.
REQ-023 SHALL size the bit counter as clog2(PAT_W), and SHALL size the rep and gap counters as CNT_W; counters count down, with no wrap-around past zero.

Reset
REQ-024 SHALL, while reset=0, immediately force state=IDLE, dout=0, dvalid=0, busy=0, done=0, all counters=0 and the pattern register=0.
REQ-025 SHALL abort a transmission on reset assertion mid-operation with no done pulse; after reset is released, the first accepted start begins a fresh transmission.

Structure
REQ-026 SHALL place the state enum and the default PATTERN, PAT_W and CNT_W constants in the shared package seq_pkg.
REQ-027 SHALL use one sub-module, seq_cnt: a loadable down-counter with a zero flag, instantiated for the bit, rep and gap counters.

Verification
REQ-028 SHALL cover default pattern: pat_sel=0, reps=1, gap=0, start pulse -> dout=0,1,0,1 with dvalid=1 on 4 consecutive cycles, then done pulse on the 5th.
REQ-029 SHALL cover runtime pattern with gap: pat_sel=1, pat_in=4'b1100, reps=2, gap=3 -> 1100, then 3 cycles with dvalid=0, then 1100, then done; busy is high for 11 cycles.
REQ-030 SHALL cover zero reps: reps=0, start -> no dvalid, done=1 on the cycle after start, then IDLE.
REQ-031 SHALL cover start while busy: start re-asserted and pat_in changed during SEND -> stream unchanged, and exactly one done pulse.
REQ-032 SHALL cover reset mid-stream: reset=0 during the 2nd bit -> all outputs 0 at once with no done; a new start after release produces the full pattern from the MSB.
REQ-033 SHALL cover loopback: dout drives din of the team's 0101 sequence detector, with PATTERN, reps=3 and gap=0 -> detector z asserts at least once per repetition with no false z during IDLE.
